// File: rtl/fifo_ptr_ctrl_if.sv
//==============================================================================
// Module      : fifo_ptr_ctrl_if
// Description : Request/status bundle between a FIFO user and fifo_ptr_ctrl.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface fifo_ptr_ctrl_if #(
    parameter int ADDR_W = 3
);
    logic              clear;
    logic              wr_req;
    logic              rd_req;
    logic              wr_en;
    logic              rd_en;
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rptr;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic              overflow;
    logic              underflow;

    modport master (
        output clear, wr_req, rd_req,
        input  wr_en, rd_en, wptr, rptr, count, full, empty,
        input  almost_full, almost_empty, overflow, underflow
    );

    modport slave (
        input  clear, wr_req, rd_req,
        output wr_en, rd_en, wptr, rptr, count, full, empty,
        output almost_full, almost_empty, overflow, underflow
    );
endinterface

`default_nettype wire

// File: rtl/fifo_ptr_ctrl.sv
//==============================================================================
// Module      : fifo_ptr_ctrl
// Description : Write/read pointer, occupancy and status-flag controller for
//               one register-file FIFO of arbitrary depth (storage external).
//               Define FIFO_PTR_ERR_EN to build sticky overflow/underflow flags.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module fifo_ptr_ctrl #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3,
    parameter int AF_TH  = DEPTH - 1,
    parameter int AE_TH  = 1
) (
    input  logic           clk,
    input  logic           n_rst,
    fifo_ptr_ctrl_if.slave bus
);

    localparam int                  c_cnt_w    = ADDR_W + 1;
    localparam logic [ADDR_W-1:0]   c_ptr_last = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0]   c_ptr_one  = ADDR_W'(1);
    localparam logic [c_cnt_w-1:0]  c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0]  c_depth    = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0]  c_af_th    = c_cnt_w'(AF_TH);
    localparam logic [c_cnt_w-1:0]  c_ae_th    = c_cnt_w'(AE_TH);
    localparam logic                c_af_rst   = (AF_TH == 0);
    localparam logic                c_ae_rst   = (AE_TH >= 0);

    // Parameter legality
    if (DEPTH < 2 || DEPTH > (1 << ADDR_W)) begin : g_chk_depth
        $error("fifo_ptr_ctrl: DEPTH=%0d illegal for ADDR_W=%0d", DEPTH, ADDR_W);
    end
    if (AE_TH < 0 || AE_TH >= AF_TH || AF_TH > DEPTH) begin : g_chk_thresh
        $error("fifo_ptr_ctrl: thresholds AE_TH=%0d AF_TH=%0d illegal for DEPTH=%0d",
               AE_TH, AF_TH, DEPTH);
    end

    logic [ADDR_W-1:0]  wptr_q, wptr_d;
    logic [ADDR_W-1:0]  rptr_q, rptr_d;
    logic [c_cnt_w-1:0] count_q, count_d;
    logic               full_q, full_d;
    logic               empty_q, empty_d;
    logic               afull_q, afull_d;
    logic               aempty_q, aempty_d;
    logic               w_wr_acc;
    logic               w_rd_acc;

    function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
        return (p == c_ptr_last) ? '0 : p + c_ptr_one;
    endfunction

    // Full wins against push and empty wins against pop; no pass-through.
    assign w_wr_acc = bus.wr_req & ~full_q  & ~bus.clear;
    assign w_rd_acc = bus.rd_req & ~empty_q & ~bus.clear;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (bus.clear) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (w_wr_acc) begin
                wptr_d = ptr_inc(wptr_q);
            end
            if (w_rd_acc) begin
                rptr_d = ptr_inc(rptr_q);
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   count_d = count_q + c_cnt_one;
                2'b01:   count_d = count_q - c_cnt_one;
                default: count_d = count_q;
            endcase
        end
    end

    // Flag flops load the decode of the next count, so they always equal
    // the decode of count_q and never glitch on request inputs.
    always_comb begin
        full_d   = (count_d == c_depth);
        empty_d  = (count_d == '0);
        afull_d  = (count_d >= c_af_th);
        aempty_d = (count_d <= c_ae_th);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= c_af_rst;
            aempty_q <= c_ae_rst;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
        end
    end

`ifdef FIFO_PTR_ERR_EN
    logic ovf_q, ovf_d;
    logic unf_q, unf_d;

    always_comb begin
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (bus.clear) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end else begin
            if (bus.wr_req & full_q) begin
                ovf_d = 1'b1;
            end
            if (bus.rd_req & empty_q) begin
                unf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
`else
    assign bus.overflow  = 1'b0;
    assign bus.underflow = 1'b0;
`endif

    assign bus.wr_en        = w_wr_acc;
    assign bus.rd_en        = w_rd_acc;
    assign bus.wptr         = wptr_q;
    assign bus.rptr         = rptr_q;
    assign bus.count        = count_q;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = afull_q;
    assign bus.almost_empty = aempty_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_ptr_ctrl.sv
//==============================================================================
// Module      : tb_fifo_ptr_ctrl
// Description : Directed plus randomized bench for fifo_ptr_ctrl against a
//               queue-based occupancy model (DEPTH=5, AF_TH=4, AE_TH=1).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_fifo_ptr_ctrl;

    localparam int DEPTH  = 5;
    localparam int ADDR_W = 3;
    localparam int AF_TH  = 4;
    localparam int AE_TH  = 1;
`ifdef FIFO_PTR_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic n_rst = 1'b0;

    always #5 clk = ~clk;

    fifo_ptr_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    fifo_ptr_ctrl #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .AF_TH  (AF_TH),
        .AE_TH  (AE_TH)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    // Reference model: contents as a queue, addresses as modular counters.
    int q[$];
    int m_wp     = 0;
    int m_rp     = 0;
    bit m_ovf    = 1'b0;
    bit m_unf    = 1'b0;
    int data_ctr = 0;

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_wp  = 0;
        m_rp  = 0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic check_state(input string where);
        int n;
        n = q.size();
        chk({where, ":wptr"},         bus.wptr,         m_wp);
        chk({where, ":rptr"},         bus.rptr,         m_rp);
        chk({where, ":count"},        bus.count,        n);
        chk({where, ":full"},         bus.full,         (n == DEPTH));
        chk({where, ":empty"},        bus.empty,        (n == 0));
        chk({where, ":almost_full"},  bus.almost_full,  (n >= AF_TH));
        chk({where, ":almost_empty"}, bus.almost_empty, (n <= AE_TH));
        chk({where, ":overflow"},     bus.overflow,     m_ovf);
        chk({where, ":underflow"},    bus.underflow,    m_unf);
    endtask

    task automatic step(input bit w, input bit r, input bit c, input string tag);
        bit was_full, was_empty, exp_wr, exp_rd;
        @(negedge clk);
        bus.wr_req = w;
        bus.rd_req = r;
        bus.clear  = c;
        #1;
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        exp_wr    = w && !was_full  && !c;
        exp_rd    = r && !was_empty && !c;
        chk({tag, ":wr_en"},     bus.wr_en, exp_wr);
        chk({tag, ":rd_en"},     bus.rd_en, exp_rd);
        chk({tag, ":wr_addr"},   bus.wptr,  m_wp);
        chk({tag, ":rd_addr"},   bus.rptr,  m_rp);
        @(posedge clk);
        if (c) begin
            model_reset();
        end else begin
            if (ERR_EN && w && was_full)  m_ovf = 1'b1;
            if (ERR_EN && r && was_empty) m_unf = 1'b1;
            if (exp_rd) begin
                void'(q.pop_front());
                m_rp = (m_rp + 1) % DEPTH;
            end
            if (exp_wr) begin
                q.push_back(data_ctr++);
                m_wp = (m_wp + 1) % DEPTH;
            end
        end
        #1;
        check_state(tag);
    endtask

    initial begin
        bit w, r, c;
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
        bus.clear  = 1'b0;
        n_rst      = 1'b0;

        #12;
        check_state("reset");
        @(negedge clk);
        n_rst = 1'b1;

        repeat (DEPTH) step(1'b1, 1'b0, 1'b0, "fill");
        step(1'b1, 1'b0, 1'b0, "push_on_full");
        step(1'b1, 1'b1, 1'b0, "both_on_full");
        repeat (2) step(1'b0, 1'b1, 1'b0, "drain_to_2");
        repeat (10) step(1'b1, 1'b1, 1'b0, "stream");
        repeat (2) step(1'b0, 1'b1, 1'b0, "drain_to_0");
        step(1'b0, 1'b1, 1'b0, "pop_on_empty");
        step(1'b1, 1'b1, 1'b1, "clear");
        step(1'b0, 1'b0, 1'b0, "idle");
        repeat (3) step(1'b1, 1'b0, 1'b0, "burst");

        // Asynchronous reset while a push is pending at count=3
        @(negedge clk);
        bus.wr_req = 1'b1;
        #2;
        n_rst = 1'b0;
        #1;
        model_reset();
        check_state("async_rst");
        bus.wr_req = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        step(1'b1, 1'b0, 1'b0, "post_rst_push");

        for (int seg = 0; seg < 6; seg++) begin
            repeat (60) begin
                w = ($urandom_range(0, 3) < (seg[0] ? 1 : 3));
                r = ($urandom_range(0, 3) < (seg[0] ? 3 : 1));
                c = ($urandom_range(0, 47) == 0);
                step(w, r, c, "random");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fifo_ptr_ctrl.md
# fifo_ptr_ctrl

Parametrised FIFO pointer and flag controller: owns the write pointer, read pointer and occupancy count for one register-file FIFO of arbitrary (non-power-of-two) depth. It is the next generation of the serial block's single write counter. It qualifies push/pop requests against full/empty and produces registered status flags, including programmable almost-full/almost-empty thresholds. It sits between the APB serial TX/RX datapaths and their storage arrays; storage itself is external.

## Interface
- DEPTH, 8, number of FIFO entries; 2 ≤ DEPTH ≤ 2^ADDR_W
- ADDR_W, 3, pointer width
- AF_TH, DEPTH-1, almost_full asserted when count ≥ AF_TH
- AE_TH, 1, almost_empty asserted when count ≤ AE_TH

Ports:
- clk  in  1  system clock, all state on rising edge
- n_rst  in  1  asynchronous, active-low reset
- clear  in  1  synchronous flush, highest priority
- wr_req  in  1  push request
- rd_req  in  1  pop request
- wr_en  out  1  accepted push, drives storage write strobe
- rd_en  out  1  accepted pop
- wptr  out  ADDR_W  storage write address
- rptr  out  ADDR_W  storage read address (head entry)
- count  out  ADDR_W+1  occupancy 0..DEPTH
- full, empty  out  1  count==DEPTH / count==0
- almost_full, almost_empty  out  1  threshold flags
- overflow, underflow  out  1  sticky error flags (see Configuration)

## Operation
- Reset (n_rst=0, async): wptr=0, rptr=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0 (unless AF_TH==0), overflow=underflow=0.
- wr_en = wr_req & ~full & ~clear. rd_en = rd_req & ~empty & ~clear. Both are combinational from inputs and registered flags only.
- Full + simultaneous wr_req/rd_req: the pop is accepted and the push is rejected. No pass-through.
- Empty + simultaneous: the push is accepted and the pop is rejected.
- Pointer update on accept: ptr ← (ptr == DEPTH-1) ? 0 : ptr+1. Pointers never take values ≥ DEPTH.
- Count: +1 on wr_en only, −1 on rd_en only, unchanged when both or neither.
- Flags decode the registered count only; no combinational path from wr_req/rd_req to the flags.
- clear=1: pointers and count go to 0, and sticky errors clear on the next edge. Requests in that cycle are ignored (wr_en=rd_en=0).
- Parameter legality (DEPTH ≤ 2^ADDR_W, AE_TH < AF_TH ≤ DEPTH) is checked at elaboration with $error.

## Timing
- Push: with wr_en high in cycle N, storage is written at wptr in cycle N. wptr, count and the flags reflect it after edge N.
- Pop: rptr addresses the head entry combinationally. With rd_en high in cycle N, the consumer samples data in cycle N, and rptr advances at edge N.
- Status latency: one cycle from accepted request to flag change. Empty→non-empty is visible one cycle after the push.
- Throughput: one push and one pop per cycle sustained when 0 < count < DEPTH.
- Reset mid-operation: all state returns to reset values immediately. Storage contents are don't-care.

## Configuration
- FIFO_PTR_ERR_EN defined: overflow is set on the edge after wr_req&full (and not clear); underflow is set on the edge after rd_req&empty. Both stay set until clear or reset.
- FIFO_PTR_ERR_EN undefined: overflow and underflow are tied to 0 and no error registers are built. Request rejection is unchanged.

## Test plan
- DEPTH=5, ADDR_W=3, AF_TH=4, AE_TH=1; reset, then 5 pushes. Required: wptr 0,1,2,3,4,0; count 5; full=1 after 5th edge; almost_full=1 after 4th; empty=0 after 1st.
- From full, wr_req=1 for 1 cycle. Required: wr_en=0, wptr stays 0, count stays 5; overflow=1 next cycle with FIFO_PTR_ERR_EN, 0 without.
- From full, wr_req=rd_req=1. Required: rd_en=1, wr_en=0, count→4, rptr 0→1, full→0.
- count=2, simultaneous push+pop for 10 cycles. Required: count stays 2, both pointers advance 10 mod 5 (wrap 4→0 observed), no flag toggles.
- From empty, rd_req=1. Required: rd_en=0, rptr unchanged, underflow=1 (ERR_EN); then clear=1 with wr_req=1: wr_en=0, all pointers/count 0, underflow=0 next cycle.
- n_rst asserted asynchronously mid-burst at count=3. Required: outputs at reset values before the next clk edge; first push after release writes address 0.
